ahb_dual_master_arbiter: RTL and testbench

Two-master AHB-lite arbiter that shares the single SoC data bus (interconnect slave port feeding memory, BIOS, counter, UART and custom ports) between the core's AHB master bridge (M0) and a second master such as a DMA or UART boot loader (M1). Each master transfer is captured in a per-master holding stage, arbitrated, then replayed onto the shared bus. The master is stalled through its HREADY until its own data phase completes. Single (non-burst) transfers only.

---
 rtl/ahb_dual_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_ahb_dual_master_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_dual_master_arbiter.sv
// Two-master AHB-lite arbiter: captures each master's single transfer in a
// holding stage, arbitrates, and replays it onto the shared bus, stalling the
// originating master until its own data phase completes.
module ahb_dual_master_arbiter #(
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR0,
    input  logic [1:0]  HTRANS0,
    input  logic        HWRITE0,
    input  logic [2:0]  HSIZE0,
    input  logic [31:0] HWDATA0,
    output logic        HREADY0,
    output logic        HRESP0,
    output logic [31:0] HRDATA0,
    input  logic [31:0] HADDR1,
    input  logic [1:0]  HTRANS1,
    input  logic        HWRITE1,
    input  logic [2:0]  HSIZE1,
    input  logic [31:0] HWDATA1,
    output logic        HREADY1,
    output logic        HRESP1,
    output logic [31:0] HRDATA1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    output logic [1:0]  DP_OWNER
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 3;
    localparam logic [1:0]  TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [SIZE_W-1:0] size;
    } addr_ctl_t;

    addr_ctl_t pend0, pend1, sel_pend;
    logic      pend0_v, pend1_v;
    logic      hold_v, hold_own;
    logic      dp_v, dp_own;
    logic      rr_last;
    logic      sel_v, sel_own;
    logic      offer0, offer1, accept;

    // HTRANS[0] only separates BUSY/SEQ from IDLE/NONSEQ, which are folded together
    logic unused_trans_lsb;
    assign unused_trans_lsb = HTRANS0[0] ^ HTRANS1[0];

    // Per-master stall: own transfer pending, or own data phase in wait state
    assign HREADY0 = !pend0_v && !(dp_v && !dp_own && !HREADY);
    assign HREADY1 = !pend1_v && !(dp_v &&  dp_own && !HREADY);
    assign offer0  = HTRANS0[1] && HREADY0;
    assign offer1  = HTRANS1[1] && HREADY1;
    assign accept  = sel_v && HREADY;

    // Arbitration: an extended address phase keeps its owner, otherwise pick a pend
    always_comb begin
        sel_v   = 1'b0;
        sel_own = 1'b0;
        if (hold_v) begin
            sel_v   = 1'b1;
            sel_own = hold_own;
        end else if (pend0_v && pend1_v) begin
            sel_v   = 1'b1;
            sel_own = PRIORITY_MODE ? !rr_last : 1'b0;
        end else if (pend0_v || pend1_v) begin
            sel_v   = 1'b1;
            sel_own = pend1_v;
        end
    end

    // Shared-bus address stage driven from the selected holding stage
    always_comb begin
        sel_pend = sel_own ? pend1 : pend0;
        HTRANS   = TRANS_IDLE;
        HADDR    = '0;
        HWRITE   = 1'b0;
        HSIZE    = '0;
        if (sel_v) begin
            HTRANS = TRANS_NONSEQ;
            HADDR  = sel_pend.addr;
            HWRITE = sel_pend.write;
            HSIZE  = sel_pend.size;
        end
    end

    // Data stage routing: write data from owner, response to owner, read data broadcast
    assign HWDATA   = dp_v ? (dp_own ? HWDATA1 : HWDATA0) : DATA_W'(0);
    assign HRESP0   = dp_v && !dp_own && HRESP;
    assign HRESP1   = dp_v &&  dp_own && HRESP;
    assign HRDATA0  = HRDATA;
    assign HRDATA1  = HRDATA;
    assign DP_OWNER = {dp_own, dp_v};

    // M0 holding stage: capture on offer, release when its address is accepted
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend0_v <= 1'b0;
            pend0   <= '0;
        end else if (offer0) begin
            pend0_v <= 1'b1;
            pend0   <= {HADDR0, HWRITE0, HSIZE0};
        end else if (accept && !sel_own) begin
            pend0_v <= 1'b0;
        end
    end

    // M1 holding stage: capture on offer, release when its address is accepted
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend1_v <= 1'b0;
            pend1   <= '0;
        end else if (offer1) begin
            pend1_v <= 1'b1;
            pend1   <= {HADDR1, HWRITE1, HSIZE1};
        end else if (accept && sel_own) begin
            pend1_v <= 1'b0;
        end
    end

    // Address/data phase tracking, address-extension hold and round-robin history
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_v   <= 1'b0;
            hold_own <= 1'b0;
            dp_v     <= 1'b0;
            dp_own   <= 1'b0;
            rr_last  <= 1'b1;
        end else if (sel_v) begin
            if (HREADY) begin
                dp_v    <= 1'b1;
                dp_own  <= sel_own;
                rr_last <= sel_own;
                hold_v  <= 1'b0;
            end else begin
                hold_v   <= 1'b1;
                hold_own <= sel_own;
            end
        end else if (HREADY) begin
            dp_v <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// Directed bench for ahb_dual_master_arbiter: instance a is fixed priority,
// instance b is round-robin; both see the same master and slave stimulus.
module tb_ahb_dual_master_arbiter;
    logic        HCLK, HRESETn;
    logic [31:0] HADDR0, HADDR1, HWDATA0, HWDATA1, HRDATA;
    logic [1:0]  HTRANS0, HTRANS1;
    logic        HWRITE0, HWRITE1, HREADY, HRESP;
    logic [2:0]  HSIZE0, HSIZE1;

    logic        a_HREADY0, a_HREADY1, a_HRESP0, a_HRESP1, a_HWRITE;
    logic [31:0] a_HRDATA0, a_HRDATA1, a_HADDR, a_HWDATA;
    logic [1:0]  a_HTRANS, a_DP_OWNER;
    logic [2:0]  a_HSIZE;
    logic        b_HREADY0, b_HREADY1, b_HRESP0, b_HRESP1, b_HWRITE;
    logic [31:0] b_HRDATA0, b_HRDATA1, b_HADDR, b_HWDATA;
    logic [1:0]  b_HTRANS, b_DP_OWNER;
    logic [2:0]  b_HSIZE;

    int checks = 0;
    int errors = 0;

    ahb_dual_master_arbiter #(.PRIORITY_MODE(1'b0)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR0(HADDR0), .HTRANS0(HTRANS0), .HWRITE0(HWRITE0), .HSIZE0(HSIZE0), .HWDATA0(HWDATA0),
        .HREADY0(a_HREADY0), .HRESP0(a_HRESP0), .HRDATA0(a_HRDATA0),
        .HADDR1(HADDR1), .HTRANS1(HTRANS1), .HWRITE1(HWRITE1), .HSIZE1(HSIZE1), .HWDATA1(HWDATA1),
        .HREADY1(a_HREADY1), .HRESP1(a_HRESP1), .HRDATA1(a_HRDATA1),
        .HADDR(a_HADDR), .HTRANS(a_HTRANS), .HWRITE(a_HWRITE), .HSIZE(a_HSIZE), .HWDATA(a_HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .DP_OWNER(a_DP_OWNER)
    );

    ahb_dual_master_arbiter #(.PRIORITY_MODE(1'b1)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR0(HADDR0), .HTRANS0(HTRANS0), .HWRITE0(HWRITE0), .HSIZE0(HSIZE0), .HWDATA0(HWDATA0),
        .HREADY0(b_HREADY0), .HRESP0(b_HRESP0), .HRDATA0(b_HRDATA0),
        .HADDR1(HADDR1), .HTRANS1(HTRANS1), .HWRITE1(HWRITE1), .HSIZE1(HSIZE1), .HWDATA1(HWDATA1),
        .HREADY1(b_HREADY1), .HRESP1(b_HRESP1), .HRDATA1(b_HRDATA1),
        .HADDR(b_HADDR), .HTRANS(b_HTRANS), .HWRITE(b_HWRITE), .HSIZE(b_HSIZE), .HWDATA(b_HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .DP_OWNER(b_DP_OWNER)
    );

    // Free-running bus clock, period 10
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        HADDR0 = '0; HTRANS0 = 2'b00; HWRITE0 = 1'b0; HSIZE0 = 3'b010; HWDATA0 = '0;
        HADDR1 = '0; HTRANS1 = 2'b00; HWRITE1 = 1'b0; HSIZE1 = 3'b010; HWDATA1 = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    endtask

    // Leaves the bench just after a falling edge, ready to drive cycle 0
    task automatic apply_reset();
        HRESETn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle_inputs();
        HRDATA = 32'h0BAD_F00D;
        repeat (2) @(posedge HCLK);
        #1;
        checks++; if (a_HTRANS !== 2'b00 || b_HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got a=%b b=%b want 00", a_HTRANS, b_HTRANS); end
        checks++; if (a_HADDR !== 32'h0 || b_HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr: got a=%h b=%h want 0", a_HADDR, b_HADDR); end
        checks++; if ({a_HWRITE, a_HSIZE, b_HWRITE, b_HSIZE} !== 8'h00) begin errors++; $display("FAIL reset_ctl: got a=%b/%b b=%b/%b want 0", a_HWRITE, a_HSIZE, b_HWRITE, b_HSIZE); end
        checks++; if (a_HWDATA !== 32'h0 || b_HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got a=%h b=%h want 0", a_HWDATA, b_HWDATA); end
        checks++; if ({a_HREADY0, a_HREADY1, b_HREADY0, b_HREADY1} !== 4'b1111) begin errors++; $display("FAIL reset_hready: got %b want 1111", {a_HREADY0, a_HREADY1, b_HREADY0, b_HREADY1}); end
        checks++; if ({a_HRESP0, a_HRESP1, b_HRESP0, b_HRESP1} !== 4'b0000) begin errors++; $display("FAIL reset_hresp: got %b want 0000", {a_HRESP0, a_HRESP1, b_HRESP0, b_HRESP1}); end
        checks++; if (a_DP_OWNER !== 2'b00 || b_DP_OWNER !== 2'b00) begin errors++; $display("FAIL reset_dp_owner: got a=%b b=%b want 00", a_DP_OWNER, b_DP_OWNER); end
        checks++; if (a_HRDATA0 !== 32'h0BAD_F00D || a_HRDATA1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL reset_hrdata_bcast: got %h/%h want 0badf00d", a_HRDATA0, a_HRDATA1); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
    endtask

    task automatic test_fixed_read();
        apply_reset();
        HTRANS0 = 2'b10; HADDR0 = 32'h1000_0004; HWRITE0 = 1'b0; HRDATA = 32'hDEAD_BEEF;
        #1;
        checks++; if (a_HREADY0 !== 1'b1) begin errors++; $display("FAIL read_c0_hready0: got %b want 1", a_HREADY0); end
        next_cycle();
        HTRANS0 = 2'b00;
        #1;
        checks++; if (a_HTRANS !== 2'b10 || a_HADDR !== 32'h1000_0004) begin errors++; $display("FAIL read_c1_addr: got %b/%h want 10/10000004", a_HTRANS, a_HADDR); end
        checks++; if (a_HREADY0 !== 1'b0) begin errors++; $display("FAIL read_c1_hready0: got %b want 0", a_HREADY0); end
        next_cycle();
        checks++; if (a_HREADY0 !== 1'b1 || a_HRDATA0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_c2_data: got %b/%h want 1/deadbeef", a_HREADY0, a_HRDATA0); end
        checks++; if (a_DP_OWNER !== 2'b01 || a_HTRANS !== 2'b00) begin errors++; $display("FAIL read_c2_owner: got %b/%b want 01/00", a_DP_OWNER, a_HTRANS); end
    endtask

    task automatic test_tie_fixed();
        apply_reset();
        HTRANS0 = 2'b10; HADDR0 = 32'h8000_0008; HWRITE0 = 1'b1; HWDATA0 = 32'h41;
        HTRANS1 = 2'b10; HADDR1 = 32'h1000_0000; HWRITE1 = 1'b1; HWDATA1 = 32'h55;
        next_cycle();
        HTRANS0 = 2'b00; HTRANS1 = 2'b00;
        #1;
        checks++; if (a_HTRANS !== 2'b10 || a_HADDR !== 32'h8000_0008 || a_HWRITE !== 1'b1) begin errors++; $display("FAIL tie0_c1_addr: got %b/%h/%b want 10/80000008/1", a_HTRANS, a_HADDR, a_HWRITE); end
        checks++; if (a_HREADY1 !== 1'b0) begin errors++; $display("FAIL tie0_c1_hready1: got %b want 0", a_HREADY1); end
        next_cycle();
        checks++; if (a_HADDR !== 32'h1000_0000 || a_HWDATA !== 32'h41) begin errors++; $display("FAIL tie0_c2_pipe: got %h/%h want 10000000/00000041", a_HADDR, a_HWDATA); end
        checks++; if (a_HREADY1 !== 1'b0 || a_HREADY0 !== 1'b1) begin errors++; $display("FAIL tie0_c2_hready: got m0=%b m1=%b want 1/0", a_HREADY0, a_HREADY1); end
        next_cycle();
        checks++; if (a_HWDATA !== 32'h55 || a_HREADY1 !== 1'b1 || a_DP_OWNER !== 2'b11) begin errors++; $display("FAIL tie0_c3_data: got %h/%b/%b want 00000055/1/11", a_HWDATA, a_HREADY1, a_DP_OWNER); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        apply_reset();
        HTRANS0 = 2'b10; HADDR0 = 32'h0000_0A00;
        HTRANS1 = 2'b10; HADDR1 = 32'h0000_0B00;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            exp_addr = (c % 2 == 1) ? 32'h0000_0A00 : 32'h0000_0B00;
            checks++; if (b_HTRANS !== 2'b10 || b_HADDR !== exp_addr) begin errors++; $display("FAIL rr_grant c%0d: got %b/%h want 10/%h", c, b_HTRANS, b_HADDR, exp_addr); end
            checks++; if (b_HREADY0 !== (c % 2 == 0) || b_HREADY1 !== (c % 2 == 1 && c >= 3)) begin errors++; $display("FAIL rr_hready c%0d: got m0=%b m1=%b want %b/%b", c, b_HREADY0, b_HREADY1, (c % 2 == 0), (c % 2 == 1 && c >= 3)); end
        end
        HTRANS0 = 2'b00; HTRANS1 = 2'b00;
    endtask

    task automatic test_wait_states();
        apply_reset();
        HREADY = 1'b0;
        HTRANS1 = 2'b10; HADDR1 = 32'h2000_0010; HWRITE1 = 1'b1;
        next_cycle();
        HTRANS1 = 2'b00;
        HTRANS0 = 2'b10; HADDR0 = 32'h3000_0020; HWRITE0 = 1'b0;
        #1;
        checks++; if (a_HTRANS !== 2'b10 || a_HADDR !== 32'h2000_0010) begin errors++; $display("FAIL wait_c1_addr: got %b/%h want 10/20000010", a_HTRANS, a_HADDR); end
        checks++; if (a_HREADY0 !== 1'b1) begin errors++; $display("FAIL wait_c1_m0_offer: got %b want 1", a_HREADY0); end
        next_cycle();
        HTRANS0 = 2'b00;
        for (int c = 2; c <= 4; c++) begin
            if (c == 4) HREADY = 1'b1;
            #1;
            checks++; if (a_HADDR !== 32'h2000_0010 || a_HWRITE !== 1'b1 || a_HREADY1 !== 1'b0) begin errors++; $display("FAIL wait_hold c%0d: got %h/%b/%b want 20000010/1/0", c, a_HADDR, a_HWRITE, a_HREADY1); end
            if (c < 4) next_cycle();
        end
        next_cycle();
        checks++; if (a_HADDR !== 32'h3000_0020 || a_HTRANS !== 2'b10) begin errors++; $display("FAIL wait_m0_after: got %b/%h want 10/30000020", a_HTRANS, a_HADDR); end
        checks++; if (a_DP_OWNER !== 2'b11 || a_HREADY1 !== 1'b1) begin errors++; $display("FAIL wait_m1_dp: got %b/%b want 11/1", a_DP_OWNER, a_HREADY1); end
    endtask

    task automatic test_error_reset();
        apply_reset();
        HTRANS1 = 2'b10; HADDR1 = 32'h4000_0000; HWRITE1 = 1'b1; HWDATA1 = 32'h1234_5678;
        next_cycle();
        HTRANS1 = 2'b00;
        HTRANS0 = 2'b10; HADDR0 = 32'h5000_0000; HWRITE0 = 1'b1;
        next_cycle();
        HTRANS0 = 2'b00;
        HRESP = 1'b1;
        #1;
        checks++; if (a_HRESP1 !== 1'b1 || a_HRESP0 !== 1'b0) begin errors++; $display("FAIL err_hresp: got m0=%b m1=%b want 0/1", a_HRESP0, a_HRESP1); end
        checks++; if (a_HWDATA !== 32'h1234_5678 || a_HTRANS !== 2'b10 || a_HADDR !== 32'h5000_0000) begin errors++; $display("FAIL err_pipe: got %h/%b/%h want 12345678/10/50000000", a_HWDATA, a_HTRANS, a_HADDR); end
        HRESETn = 1'b0;
        #1;
        checks++; if (a_HTRANS !== 2'b00 || a_HADDR !== 32'h0 || a_HWRITE !== 1'b0 || a_HSIZE !== 3'b000) begin errors++; $display("FAIL async_rst_addr: got %b/%h/%b/%b want idle zeros", a_HTRANS, a_HADDR, a_HWRITE, a_HSIZE); end
        checks++; if (a_HWDATA !== 32'h0 || a_DP_OWNER !== 2'b00) begin errors++; $display("FAIL async_rst_dp: got %h/%b want 0/00", a_HWDATA, a_DP_OWNER); end
        checks++; if ({a_HREADY0, a_HREADY1, a_HRESP0, a_HRESP1} !== 4'b1100) begin errors++; $display("FAIL async_rst_resp: got %b want 1100", {a_HREADY0, a_HREADY1, a_HRESP0, a_HRESP1}); end
        HRESP = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        idle_inputs();
        test_reset();
        test_fixed_read();
        test_tie_fixed();
        test_round_robin();
        test_wait_states();
        test_error_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
